// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer.
//   - ROB_WIDTH_DEF : default ROB index width
//   - F3_*          : RV32I funct3 encodings for loads and stores
//   - lsbState_t    : memory-access FSM states
package load_store_buffer_pkg;

  localparam int ROB_WIDTH_DEF = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } lsbState_t;

endpackage

// File: rtl/load_store_buffer_load_extend.sv
// lsb_load_extend: combinational sign/zero extension of right-aligned load
// data according to the RV32I load funct3.
//   funct3  in  3   load size/signedness
//   rawData in  32  right-aligned raw memory data
//   extData out 32  extended load result
module lsb_load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rawData,
  output logic [31:0] extData
);

  always_comb begin
    extData = rawData;
    case (funct3)
      F3_LB:   extData = {{24{rawData[7]}}, rawData[7:0]};
      F3_LH:   extData = {{16{rawData[15]}}, rawData[15:0]};
      F3_LW:   extData = rawData;
      F3_LBU:  extData = {24'd0, rawData[7:0]};
      F3_LHU:  extData = {16'd0, rawData[15:0]};
      default: extData = rawData;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order circular buffer of loads/stores waiting on
// their operands. Only the head entry issues to memory; stores additionally
// wait until they reach the ROB head. Results are broadcast on lsbUpdate.
//
// Ports:
//   clockIn, resetIn (async, active low), clear (mispredict flush)
//   add*        : allocation request from the issue unit; full = back-pressure
//   rs*         : reservation-station result broadcast (snooped)
//   robBeginId, beginValid : ROB head, gates store issue
//   mem*        : single-outstanding memory request / completion
//   lsb*        : result broadcast (also snooped by this buffer)
//
// Build option: define LSB_CDB_BYPASS_EN to let an allocating entry capture
// an operand broadcast in the same cycle. Without it the issue unit must not
// allocate with a tag that is being broadcast that cycle.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int LSB_WIDTH = 3,
  parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 clear,
  input  logic                 addValid,
  input  logic                 addStore,
  input  logic [2:0]           addFunct3,
  input  logic [ROB_WIDTH-1:0] addRobIndex,
  input  logic [31:0]          addOffset,
  input  logic                 addRs1Ready,
  input  logic [ROB_WIDTH-1:0] addRs1Dep,
  input  logic [31:0]          addRs1Value,
  input  logic                 addRs2Ready,
  input  logic [ROB_WIDTH-1:0] addRs2Dep,
  input  logic [31:0]          addRs2Value,
  output logic                 full,
  input  logic                 rsUpdate,
  input  logic [ROB_WIDTH-1:0] rsRobIndex,
  input  logic [31:0]          rsUpdateVal,
  input  logic [ROB_WIDTH-1:0] robBeginId,
  input  logic                 beginValid,
  output logic                 memRequest,
  output logic                 memWrite,
  output logic [2:0]           memFunct3,
  output logic [31:0]          memAddr,
  output logic [31:0]          memWData,
  input  logic                 memDone,
  input  logic [31:0]          memRData,
  output logic                 lsbUpdate,
  output logic [ROB_WIDTH-1:0] lsbRobIndex,
  output logic [31:0]          lsbUpdateVal
);

  localparam int LSB_SIZE = 1 << LSB_WIDTH;
  localparam int CNT_W    = LSB_WIDTH + 1;

  typedef struct packed {
    logic                 valid;
    logic                 isStore;
    logic [2:0]           funct3;
    logic [ROB_WIDTH-1:0] robIdx;
    logic [31:0]          offset;
    logic                 rs1Rdy;
    logic [ROB_WIDTH-1:0] rs1Dep;
    logic [31:0]          rs1Val;
    logic                 rs2Rdy;
    logic [ROB_WIDTH-1:0] rs2Dep;
    logic [31:0]          rs2Val;
  } lsbEntry_t;

  lsbEntry_t            entries [LSB_SIZE];
  lsbEntry_t            headEntry;
  lsbEntry_t            newEntry;
  logic [LSB_WIDTH-1:0] head;
  logic [LSB_WIDTH-1:0] tail;
  logic [CNT_W-1:0]     count;
  lsbState_t            state;
  lsbState_t            stateNext;
  logic                 headEligible;
  logic                 issue;
  logic                 complete;
  logic                 doAlloc;
  logic [31:0]          extData;

  assign headEntry = entries[head];
  assign full      = (count >= CNT_W'(LSB_SIZE - 1));
  // clear wins over a same-cycle allocation; a completely full buffer drops it
  assign doAlloc   = addValid && !clear && (count != CNT_W'(LSB_SIZE));

  assign headEligible = headEntry.valid && headEntry.rs1Rdy &&
                        (!headEntry.isStore ||
                         (headEntry.rs2Rdy && beginValid &&
                          (robBeginId == headEntry.robIdx)));

  lsb_load_extend uExtend (
    .funct3  (memFunct3),
    .rawData (memRData),
    .extData (extData)
  );

  always_comb begin
    newEntry = '{valid:   1'b1,
                 isStore: addStore,
                 funct3:  addFunct3,
                 robIdx:  addRobIndex,
                 offset:  addOffset,
                 rs1Rdy:  addRs1Ready,
                 rs1Dep:  addRs1Dep,
                 rs1Val:  addRs1Value,
                 rs2Rdy:  addRs2Ready,
                 rs2Dep:  addRs2Dep,
                 rs2Val:  addRs2Value};
`ifdef LSB_CDB_BYPASS_EN
    if (!addRs1Ready && rsUpdate && rsRobIndex == addRs1Dep) begin
      newEntry.rs1Rdy = 1'b1;
      newEntry.rs1Val = rsUpdateVal;
    end else if (!addRs1Ready && lsbUpdate && lsbRobIndex == addRs1Dep) begin
      newEntry.rs1Rdy = 1'b1;
      newEntry.rs1Val = lsbUpdateVal;
    end
    if (!addRs2Ready && rsUpdate && rsRobIndex == addRs2Dep) begin
      newEntry.rs2Rdy = 1'b1;
      newEntry.rs2Val = rsUpdateVal;
    end else if (!addRs2Ready && lsbUpdate && lsbRobIndex == addRs2Dep) begin
      newEntry.rs2Rdy = 1'b1;
      newEntry.rs2Val = lsbUpdateVal;
    end
`endif
  end

  // FSM next state. DRAIN keeps the abandoned request alive until memory
  // acknowledges it, so the memory side never sees a withdrawn request.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (!clear && headEligible) begin
          stateNext = BUSY;
          issue     = 1'b1;
        end
      end
      BUSY: begin
        if (memDone) begin
          stateNext = IDLE;
          complete  = !clear;
        end else if (clear) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (memDone) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) state <= IDLE;
    else          state <= stateNext;
  end

  // Pointers and occupancy
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (doAlloc)  tail <= tail + 1'b1;
      if (complete) head <= head + 1'b1;
      count <= count + CNT_W'(doAlloc) - CNT_W'(complete);
    end
  end

  // Entry storage: operand snooping, allocation, pop
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      for (int i = 0; i < LSB_SIZE; i++) entries[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < LSB_SIZE; i++) entries[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (entries[i].valid && !entries[i].rs1Rdy) begin
          if (rsUpdate && rsRobIndex == entries[i].rs1Dep) begin
            entries[i].rs1Rdy <= 1'b1;
            entries[i].rs1Val <= rsUpdateVal;
          end else if (lsbUpdate && lsbRobIndex == entries[i].rs1Dep) begin
            entries[i].rs1Rdy <= 1'b1;
            entries[i].rs1Val <= lsbUpdateVal;
          end
        end
        if (entries[i].valid && !entries[i].rs2Rdy) begin
          if (rsUpdate && rsRobIndex == entries[i].rs2Dep) begin
            entries[i].rs2Rdy <= 1'b1;
            entries[i].rs2Val <= rsUpdateVal;
          end else if (lsbUpdate && lsbRobIndex == entries[i].rs2Dep) begin
            entries[i].rs2Rdy <= 1'b1;
            entries[i].rs2Val <= lsbUpdateVal;
          end
        end
      end
      // tail never equals head here while head is live (alloc blocked at SIZE)
      if (doAlloc)  entries[tail]       <= newEntry;
      if (complete) entries[head].valid <= 1'b0;
    end
  end

  // Registered memory request and result broadcast
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      memRequest   <= 1'b0;
      memWrite     <= 1'b0;
      memFunct3    <= '0;
      memAddr      <= '0;
      memWData     <= '0;
      lsbUpdate    <= 1'b0;
      lsbRobIndex  <= '0;
      lsbUpdateVal <= '0;
    end else begin
      lsbUpdate <= complete;
      if (complete) begin
        lsbRobIndex  <= headEntry.robIdx;
        lsbUpdateVal <= headEntry.isStore ? 32'd0 : extData;
      end
      if (issue) begin
        memRequest <= 1'b1;
        memWrite   <= headEntry.isStore;
        memFunct3  <= headEntry.funct3;
        memAddr    <= headEntry.rs1Val + headEntry.offset;
        memWData   <= headEntry.rs2Val;
      end else if (state != IDLE && memDone) begin
        memRequest <= 1'b0;
        memWrite   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b0;
  logic        clear = 1'b0;
  logic        addValid = 1'b0, addStore = 1'b0;
  logic [2:0]  addFunct3 = '0;
  logic [3:0]  addRobIndex = '0;
  logic [31:0] addOffset = '0;
  logic        addRs1Ready = 1'b0;
  logic [3:0]  addRs1Dep = '0;
  logic [31:0] addRs1Value = '0;
  logic        addRs2Ready = 1'b0;
  logic [3:0]  addRs2Dep = '0;
  logic [31:0] addRs2Value = '0;
  logic        full;
  logic        rsUpdate = 1'b0;
  logic [3:0]  rsRobIndex = '0;
  logic [31:0] rsUpdateVal = '0;
  logic [3:0]  robBeginId = '0;
  logic        beginValid = 1'b0;
  logic        memRequest, memWrite;
  logic [2:0]  memFunct3;
  logic [31:0] memAddr, memWData;
  logic        memDone = 1'b0;
  logic [31:0] memRData = '0;
  logic        lsbUpdate;
  logic [3:0]  lsbRobIndex;
  logic [31:0] lsbUpdateVal;

  int checks = 0;
  int errors = 0;

  load_store_buffer dut (
    .clockIn(clockIn), .resetIn(resetIn), .clear(clear),
    .addValid(addValid), .addStore(addStore), .addFunct3(addFunct3),
    .addRobIndex(addRobIndex), .addOffset(addOffset),
    .addRs1Ready(addRs1Ready), .addRs1Dep(addRs1Dep), .addRs1Value(addRs1Value),
    .addRs2Ready(addRs2Ready), .addRs2Dep(addRs2Dep), .addRs2Value(addRs2Value),
    .full(full),
    .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex), .rsUpdateVal(rsUpdateVal),
    .robBeginId(robBeginId), .beginValid(beginValid),
    .memRequest(memRequest), .memWrite(memWrite), .memFunct3(memFunct3),
    .memAddr(memAddr), .memWData(memWData),
    .memDone(memDone), .memRData(memRData),
    .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex), .lsbUpdateVal(lsbUpdateVal)
  );

  always #5 clockIn = ~clockIn;

  task automatic tick();
    @(posedge clockIn);
    #1;
  endtask

  task automatic setAdd(input logic st, input logic [2:0] f3, input logic [3:0] rob,
                        input logic [31:0] off, input logic r1Rdy, input logic [3:0] r1Dep,
                        input logic [31:0] r1Val, input logic [31:0] r2Val);
    addValid = 1'b1; addStore = st; addFunct3 = f3; addRobIndex = rob;
    addOffset = off; addRs1Ready = r1Rdy; addRs1Dep = r1Dep; addRs1Value = r1Val;
    addRs2Ready = 1'b1; addRs2Dep = '0; addRs2Value = r2Val;
  endtask

  task automatic alloc(input logic st, input logic [2:0] f3, input logic [3:0] rob,
                       input logic [31:0] off, input logic r1Rdy, input logic [3:0] r1Dep,
                       input logic [31:0] r1Val, input logic [31:0] r2Val);
    setAdd(st, f3, rob, off, r1Rdy, r1Dep, r1Val, r2Val);
    tick();
    addValid = 1'b0;
  endtask

  // Waits (bounded) for a request, records it, answers with memDone and
  // records the broadcast that follows.
  task automatic serveMem(input logic [31:0] rdata, output logic ok,
                          output logic [31:0] addr, output logic [31:0] wdata,
                          output logic wr, output logic [2:0] f3,
                          output logic upd, output logic [3:0] idx, output logic [31:0] val);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (memRequest) ok = 1'b1;
      else tick();
    end
    addr = memAddr; wdata = memWData; wr = memWrite; f3 = memFunct3;
    memDone = 1'b1; memRData = rdata;
    tick();
    memDone = 1'b0;
    upd = lsbUpdate; idx = lsbRobIndex; val = lsbUpdateVal;
  endtask

  task automatic test_reset();
    resetIn = 1'b0;
    #2;
    checks++;
    if ({memRequest, memWrite, lsbUpdate, full} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {memRequest, memWrite, lsbUpdate, full});
    end
    checks++;
    if ({memAddr, memWData, lsbUpdateVal} !== 96'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0", memAddr, memWData, lsbUpdateVal);
    end
    checks++;
    if ({lsbRobIndex, memFunct3} !== 7'd0) begin
      errors++; $display("FAIL reset_idx got %h %h want 0", lsbRobIndex, memFunct3);
    end
    tick();
    resetIn = 1'b1;
    tick();
  endtask

  task automatic test_load_word();
    logic ok, wr, upd; logic [31:0] a, wd, v; logic [2:0] f; logic [3:0] ix;
    alloc(1'b0, F3_LW, 4'd1, 32'd4, 1'b1, 4'd0, 32'h100, 32'd0);
    checks++;
    if (memRequest !== 1'b0) begin errors++; $display("FAIL lw_early got %b want 0", memRequest); end
    tick();
    checks++;
    if (memRequest !== 1'b1) begin errors++; $display("FAIL lw_req_latency got %b want 1", memRequest); end
    serveMem(32'hDEADBEEF, ok, a, wd, wr, f, upd, ix, v);
    checks++;
    if (!ok || a !== 32'h104 || wr !== 1'b0 || f !== F3_LW) begin
      errors++; $display("FAIL lw_req got ok=%b addr=%h wr=%b f3=%h want 1 104 0 2", ok, a, wr, f);
    end
    checks++;
    if (upd !== 1'b1 || ix !== 4'd1 || v !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_result got %b %h %h want 1 1 deadbeef", upd, ix, v);
    end
    checks++;
    if (memRequest !== 1'b0) begin errors++; $display("FAIL lw_req_drop got %b want 0", memRequest); end
    tick();
    checks++;
    if (lsbUpdate !== 1'b0) begin errors++; $display("FAIL lw_pulse got %b want 0", lsbUpdate); end
  endtask

  task automatic test_extend();
    logic ok, wr, upd; logic [31:0] a, wd, v; logic [2:0] f; logic [3:0] ix;
    logic [2:0]  f3s [4] = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
    logic [31:0] raw [4] = '{32'h00000080, 32'h00000080, 32'h00008001, 32'h00008001};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    for (int k = 0; k < 4; k++) begin
      alloc(1'b0, f3s[k], 4'd2, 32'd0, 1'b1, 4'd0, 32'h40, 32'd0);
      serveMem(raw[k], ok, a, wd, wr, f, upd, ix, v);
      checks++;
      if (!ok || upd !== 1'b1 || v !== exp[k]) begin
        errors++; $display("FAIL extend_%0d got ok=%b upd=%b val=%h want %h", k, ok, upd, v, exp[k]);
      end
    end
  endtask

  task automatic test_store();
    logic ok, wr, upd; logic [31:0] a, wd, v; logic [2:0] f; logic [3:0] ix;
    robBeginId = 4'd3; beginValid = 1'b1;
    alloc(1'b1, F3_SW, 4'd5, 32'd8, 1'b1, 4'd0, 32'h300, 32'h12345678);
    tick(); tick(); tick();
    checks++;
    if (memRequest !== 1'b0) begin errors++; $display("FAIL st_not_head got %b want 0", memRequest); end
    robBeginId = 4'd5;
    serveMem(32'hFFFFFFFF, ok, a, wd, wr, f, upd, ix, v);
    checks++;
    if (!ok || wr !== 1'b1 || a !== 32'h308 || wd !== 32'h12345678 || f !== F3_SW) begin
      errors++; $display("FAIL st_req got ok=%b wr=%b addr=%h wd=%h f3=%h want 1 1 308 12345678 2", ok, wr, a, wd, f);
    end
    checks++;
    if (upd !== 1'b1 || ix !== 4'd5 || v !== 32'd0) begin
      errors++; $display("FAIL st_result got %b %h %h want 1 5 0", upd, ix, v);
    end
    beginValid = 1'b0;
  endtask

  task automatic test_dependency();
    logic ok, wr, upd; logic [31:0] a, wd, v; logic [2:0] f; logic [3:0] ix;
    alloc(1'b0, F3_LW, 4'd6, 32'h10, 1'b0, 4'd2, 32'd0, 32'd0);
    tick(); tick(); tick();
    checks++;
    if (memRequest !== 1'b0) begin errors++; $display("FAIL dep_wait got %b want 0", memRequest); end
    rsUpdate = 1'b1; rsRobIndex = 4'd2; rsUpdateVal = 32'h200;
    tick();
    rsUpdate = 1'b0;
    serveMem(32'h55, ok, a, wd, wr, f, upd, ix, v);
    checks++;
    if (!ok || a !== 32'h210 || v !== 32'h55 || ix !== 4'd6) begin
      errors++; $display("FAIL dep_rs got ok=%b addr=%h val=%h idx=%h want 1 210 55 6", ok, a, v, ix);
    end
    // second load waits on the first load's own broadcast
    alloc(1'b0, F3_LW, 4'd7, 32'd0, 1'b1, 4'd0, 32'h80, 32'd0);
    alloc(1'b0, F3_LW, 4'd8, 32'h4, 1'b0, 4'd7, 32'd0, 32'd0);
    serveMem(32'h400, ok, a, wd, wr, f, upd, ix, v);
    serveMem(32'h1, ok, a, wd, wr, f, upd, ix, v);
    checks++;
    if (!ok || a !== 32'h404 || ix !== 4'd8) begin
      errors++; $display("FAIL dep_lsb got ok=%b addr=%h idx=%h want 1 404 8", ok, a, ix);
    end
  endtask

  task automatic test_full_wrap();
    logic ok, wr, upd; logic [31:0] a, wd, v; logic [2:0] f; logic [3:0] ix;
    int waitCnt;
    resetIn = 1'b0; tick(); resetIn = 1'b1; tick();
    for (int k = 0; k < 7; k++) begin
      if (k == 6) begin
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL full_at6 got %b want 0", full); end
      end
      alloc(1'b0, F3_LW, 4'(k), 32'(4 * k), 1'b0, 4'd9, 32'd0, 32'd0);
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_at7 got %b want 1", full); end
    rsUpdate = 1'b1; rsRobIndex = 4'd9; rsUpdateVal = 32'h1000;
    tick();
    rsUpdate = 1'b0;
    waitCnt = 0;
    while (!memRequest && waitCnt < 20) begin tick(); waitCnt++; end
    // pop of entry 0 and allocation into slot 7 in the same cycle
    setAdd(1'b0, F3_LW, 4'd7, 32'd28, 1'b1, 4'd0, 32'h1000, 32'd0);
    memDone = 1'b1; memRData = 32'd0;
    tick();
    addValid = 1'b0; memDone = 1'b0;
    checks++;
    if (lsbUpdate !== 1'b1 || lsbRobIndex !== 4'd0 || full !== 1'b1) begin
      errors++; $display("FAIL pop_alloc got upd=%b idx=%h full=%b want 1 0 1", lsbUpdate, lsbRobIndex, full);
    end
    alloc(1'b0, F3_LW, 4'd8, 32'd32, 1'b1, 4'd0, 32'h1000, 32'd0);  // wraps into slot 0
    alloc(1'b0, F3_LW, 4'd9, 32'd36, 1'b1, 4'd0, 32'h1000, 32'd0);  // buffer full: dropped
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_at8 got %b want 1", full); end
    for (int k = 1; k <= 8; k++) begin
      serveMem(32'd0, ok, a, wd, wr, f, upd, ix, v);
      checks++;
      if (!ok || ix !== 4'(k) || a !== 32'h1000 + 32'(4 * k)) begin
        errors++; $display("FAIL drain_%0d got ok=%b idx=%h addr=%h want %h %h", k, ok, ix, a, k, 32'h1000 + 4 * k);
      end
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (memRequest !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL drop_full got req=%b full=%b want 0 0", memRequest, full);
    end
  endtask

  task automatic test_clear();
    logic ok, wr, upd; logic [31:0] a, wd, v; logic [2:0] f; logic [3:0] ix;
    alloc(1'b0, F3_LW, 4'd3, 32'd0, 1'b1, 4'd0, 32'h500, 32'd0);
    tick();
    checks++;
    if (memRequest !== 1'b1) begin errors++; $display("FAIL clr_issue got %b want 1", memRequest); end
    setAdd(1'b0, F3_LW, 4'd4, 32'd0, 1'b1, 4'd0, 32'h700, 32'd0);  // dropped by clear
    clear = 1'b1;
    tick();
    clear = 1'b0; addValid = 1'b0;
    checks++;
    if (memRequest !== 1'b1 || lsbUpdate !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL clr_hold got req=%b upd=%b full=%b want 1 0 0", memRequest, lsbUpdate, full);
    end
    alloc(1'b0, F3_LW, 4'd10, 32'h20, 1'b1, 4'd0, 32'h600, 32'd0);
    tick();
    checks++;
    if (memRequest !== 1'b1 || memAddr !== 32'h500) begin
      errors++; $display("FAIL clr_drain got req=%b addr=%h want 1 500", memRequest, memAddr);
    end
    memDone = 1'b1; memRData = 32'hAAAA;
    tick();
    memDone = 1'b0;
    checks++;
    if (memRequest !== 1'b0 || lsbUpdate !== 1'b0) begin
      errors++; $display("FAIL clr_discard got req=%b upd=%b want 0 0", memRequest, lsbUpdate);
    end
    serveMem(32'h77, ok, a, wd, wr, f, upd, ix, v);
    checks++;
    if (!ok || a !== 32'h620 || upd !== 1'b1 || ix !== 4'd10 || v !== 32'h77) begin
      errors++; $display("FAIL clr_next got ok=%b addr=%h upd=%b idx=%h val=%h want 1 620 1 a 77", ok, a, upd, ix, v);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (memRequest !== 1'b0) begin errors++; $display("FAIL clr_flushed got %b want 0", memRequest); end
  endtask

  task automatic test_reset_mid();
    alloc(1'b0, F3_LW, 4'd1, 32'd0, 1'b1, 4'd0, 32'h900, 32'd0);
    tick();
    checks++;
    if (memRequest !== 1'b1) begin errors++; $display("FAIL rst_mid_issue got %b want 1", memRequest); end
    resetIn = 1'b0;
    #1;
    checks++;
    if (memRequest !== 1'b0) begin errors++; $display("FAIL rst_mid_async got %b want 0", memRequest); end
    tick();
    resetIn = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (memRequest !== 1'b0 || lsbUpdate !== 1'b0) begin
      errors++; $display("FAIL rst_mid_abandon got req=%b upd=%b want 0 0", memRequest, lsbUpdate);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_extend();
    test_store();
    test_dependency();
    test_full_wrap();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_buffer.md
LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer
Interface
REQ-001 Parameter LSB_WIDTH, default 3; buffer holds LSB_SIZE = 2**LSB_WIDTH entries.
REQ-002 Parameter ROB_WIDTH, default 4; ROB index width.
REQ-003 clockIn  in  1  single clock; all state on rising edge.
REQ-004 resetIn  in  1  asynchronous, active-low reset.
REQ-005 clear  in  1  mispredict flush from the ROB.
REQ-006 addValid/addStore/addFunct3  in  1/1/3  allocate strobe, store flag, RV32I funct3.
REQ-007 addRobIndex/addOffset  in  ROB_WIDTH/32  owning ROB entry, sign-extended immediate.
REQ-008 addRs1Ready/addRs1Dep/addRs1Value  in  1/ROB_WIDTH/32  base operand, or its ROB tag.
REQ-009 addRs2Ready/addRs2Dep/addRs2Value  in  1/ROB_WIDTH/32  store-data operand, or its ROB tag.
REQ-010 full  out  1  no further allocation accepted.
REQ-011 rsUpdate/rsRobIndex/rsUpdateVal  in  1/ROB_WIDTH/32  reservation-station result broadcast.
REQ-012 robBeginId/beginValid  in  ROB_WIDTH/1  ROB head index; ROB non-empty.
REQ-013 memRequest/memWrite/memFunct3  out  1/1/3  memory access request, direction, size.
REQ-014 memAddr/memWData  out  32/32  byte address, right-aligned store data.
REQ-015 memDone/memRData  in  1/32  one-cycle completion pulse, right-aligned raw load data.
REQ-016 lsbUpdate/lsbRobIndex/lsbUpdateVal  out  1/ROB_WIDTH/32  result broadcast to ROB and RS.
Function
REQ-017 Entries form a circular FIFO; head/tail wrap modulo LSB_SIZE; a 0..LSB_SIZE count distinguishes full from empty.
REQ-018 full = (count >= LSB_SIZE-1), giving one slot of slack for the registered allocate; addValid while count == LSB_SIZE is ignored.
REQ-019 Every cycle, each valid entry waiting on tag T captures the value and sets ready when rsUpdate && rsRobIndex==T, or lsbUpdate && lsbRobIndex==T (both broadcasts snooped).
REQ-020 Only the head entry issues, in program order; load eligible when rs1 ready; store eligible when rs1 and rs2 ready, beginValid, and robBeginId == entry ROB index.
REQ-021 FSM states IDLE, BUSY, DRAIN; IDLE->BUSY when head eligible; request registered, memRequest high exactly one cycle after eligibility.
REQ-022 memAddr = rs1 + offset (32-bit wrap); memWData = rs2; memFunct3 = funct3; memRequest held high until memDone.
REQ-023 BUSY->IDLE on memDone; head pops in that cycle; lsbUpdate pulses one cycle later carrying the entry ROB index.
REQ-024 Load result: funct3 000 LB / 001 LH sign-extend, 010 LW as-is, 100 LBU / 101 LHU zero-extend; store result value = 0.
REQ-025 Allocate and pop in the same cycle leave count unchanged; allocate into a full buffer is dropped.
REQ-026 clear: all entries invalidated, head=tail=count=0, lsbUpdate forced low next cycle; if BUSY, FSM -> DRAIN and memRequest held until memDone, then IDLE with the result discarded; no new issue during DRAIN.
REQ-027 clear and addValid in the same cycle: clear wins, the allocation is dropped.
Reset
REQ-028 resetIn low: head, tail, count = 0, all entries invalid, FSM IDLE, memRequest = memWrite = lsbUpdate = 0, memAddr = memWData = lsbUpdateVal = 0, lsbRobIndex = 0, memFunct3 = 0, full = 0; reset asserted mid-access abandons the access.
Configuration
REQ-029 Macro LSB_CDB_BYPASS_EN defined: an allocating entry whose operand tag matches a broadcast in the same cycle captures that value and is ready.
REQ-030 LSB_CDB_BYPASS_EN undefined: no same-cycle capture; the issue unit must not allocate with a tag being broadcast that cycle.
Structure
REQ-031 Shared package holds the funct3 load/store encodings, the FSM state enum and the ROB_WIDTH default.
REQ-032 One sub-module, lsb_load_extend: combinational funct3-driven sign/zero extension of memRData.
Verification
REQ-033 Load LW, rs1=0x100 ready, offset 4, memRData 0xDEADBEEF -> memAddr 0x104; lsbUpdateVal 0xDEADBEEF, one cycle after memDone.
REQ-034 LB with memRData 0x00000080 -> lsbUpdateVal 0xFFFFFF80; LBU -> 0x00000080.
REQ-035 SW ROB index 5, robBeginId 3 -> no memRequest; robBeginId becomes 5 -> memWrite=1, lsbUpdateVal 0.
REQ-036 Load with rs1Dep=2, then rsUpdate idx 2 val 0x200 -> issues with memAddr 0x200+offset.
REQ-037 Allocate 7 entries, LSB_SIZE 8 -> full=1; simultaneous pop and allocate keep count 7; tail wraps 7->0.
REQ-038 clear while BUSY -> memRequest held until memDone, no lsbUpdate, buffer empty, next allocation at index 0.
